ace_divider: RTL
================

# ace_divider

Sequential unsigned restoring divider. It is the shift-and-subtract counterpart of the project's shift-and-add multiplier. A Start pulse loads Dividend and Divisor. The block then runs one shift/trial-subtract iteration per quotient bit and raises Ready for one cycle when Quotient and Remainder are valid. It sits beside the multiplier in the arithmetic unit and uses the same Start/Ready handshake.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 2..32.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low; clock Clock.
- Start  in  1  request; sampled only in IDLE.
- Dividend  in  WIDTH  unsigned numerator; must be stable from the Start edge through the following edge.
- Divisor  in  WIDTH  unsigned denominator; same stability rule as Dividend.
- Ready  out  1  one-cycle pulse; results are valid.
- Busy  out  1  high in every state except IDLE.
- Div_By_Zero  out  1  valid with Ready; high when Divisor was 0; held until the next LOAD.
- Quotient  out  WIDTH  registered result; held until the next LOAD.
- Remainder  out  WIDTH  registered result; held until the next LOAD.

## Operation
- States: IDLE, LOAD, SHIFT, TEST, CHECK, DONE. Encoding constants live in the package.
- IDLE -> LOAD when Start=1; otherwise stay in IDLE.
- LOAD:
  - asserts Load_Regs: A <= 0 (WIDTH+1 bits), Q <= Dividend, D <= Divisor, P <= WIDTH, Div_By_Zero <= 0.
  - if Divisor==0: go to DONE instead, setting Div_By_Zero <= 1, Q <= all ones, A <= {0,Dividend}.
  - otherwise -> SHIFT.
- SHIFT: Shift_Regs; {A,Q} <= {A,Q} << 1, Q[0] <= 0. -> TEST.
- TEST:
  - Sub_Regs and Decr_P.
  - diff = A - {0,D}, computed WIDTH+2 bits wide.
  - if the sign bit of diff is 0: A <= diff, Q[0] <= 1; else A is unchanged.
  - P <= P-1.
  - -> CHECK.
- CHECK: P==0 -> DONE, else -> SHIFT.
- DONE: Ready=1, Quotient/Remainder registers show Q and A[WIDTH-1:0]. -> IDLE unconditionally.
- Start outside IDLE is ignored, including during DONE. Start held high re-triggers from IDLE.
- P is $clog2(WIDTH+1) bits wide. It never underflows because CHECK exits at 0.
- Control signals are Moore outputs decoded from the current state only, with defaults of 0 and no latches.
- Next-state logic has a default branch to IDLE; unused encodings recover to IDLE in one cycle.
- Reset is synchronous and active-low. At Reset=0 on any edge:
  - state <= IDLE;
  - Ready, Busy and Div_By_Zero = 0;
  - Quotient and Remainder = 0; A, Q, D and P cleared.
  - Reset mid-operation aborts the operation with no Ready pulse.

## Timing
- Start sampled high at edge E0, state LOAD after E0. The exit edge from LOAD is E1.
- Normal division:
  - iterations occupy edges E1..E(3*WIDTH);
  - DONE is entered at E(3*WIDTH+1); for WIDTH=8 that is E25.
- Divide by zero: DONE is entered at E1.
- Ready is high for exactly one cycle, then IDLE follows. The earliest next Start is sampled at the edge ending that IDLE cycle.
- Busy rises at E0 and falls at the edge leaving DONE.

## Structure
- Package ace_div_pkg:
  - state encoding constants (3-bit);
  - the default WIDTH;
  - the P counter width function.
- Sub-module ace_div_controller:
  - FSM only;
  - inputs Clock, Reset, Start, Div_Zero (Divisor==0), P_Zero;
  - outputs Ready, Busy, Load_Regs, Shift_Regs, Sub_Regs, Decr_P, Set_DBZ.
- The datapath (A, Q, D, P, subtractor, result registers) lives in ace_divider and instantiates the controller.

## Test plan
- WIDTH=8, Dividend=100, Divisor=7, Start at E0 -> Ready at E25 only, Quotient=14, Remainder=2, Div_By_Zero=0, Busy high E0..DONE.
- 255/1 -> Quotient=255, Remainder=0. 5/9 -> Quotient=0, Remainder=5. 255/255 -> 1, 0.
- Dividend=200, Divisor=0 -> Ready at E1, Div_By_Zero=1, Quotient=255, Remainder=200.
- Reset=0 asserted at the edge while the FSM is in TEST of iteration 3 -> next state IDLE, all outputs 0, no Ready pulse; a new 100/7 afterwards gives 14, 2.
- Start pulsed at E5 and during DONE of a running operation -> ignored; results unchanged; exactly one Ready.
- Start held high continuously -> back-to-back operations; for WIDTH=8, Ready pulses every 27 cycles; Quotient/Remainder hold between operations.

Source files
------------

// File: rtl/ace_div_pkg.sv
// ace_div_pkg: shared state encoding, default width and counter sizing for the restoring divider
package ace_div_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        TEST  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic int p_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/ace_div_controller.sv
// ace_div_controller: Start/Ready sequencing FSM for the shift/trial-subtract divider
module ace_div_controller
    import ace_div_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic Start,
    input  logic Div_Zero,
    input  logic P_Zero,
    output logic Ready,
    output logic Busy,
    output logic Load_Regs,
    output logic Shift_Regs,
    output logic Sub_Regs,
    output logic Decr_P,
    output logic Set_DBZ
);

    state_t state, next_state;

    // state register, synchronous active-low reset back to IDLE
    always_ff @(posedge Clock)
        state <= !Reset ? IDLE : next_state;

    // next-state and control decode; a zero divisor skips straight to DONE
    always_comb begin
        next_state = IDLE;
        Ready      = 1'b0;
        Load_Regs  = 1'b0;
        Shift_Regs = 1'b0;
        Sub_Regs   = 1'b0;
        Decr_P     = 1'b0;
        Set_DBZ    = 1'b0;
        Busy       = state != IDLE;
        case (state)
            IDLE: next_state = Start ? LOAD : IDLE;
            LOAD: begin
                Load_Regs  = 1'b1;
                Set_DBZ    = Div_Zero;
                next_state = Div_Zero ? DONE : SHIFT;
            end
            SHIFT: begin
                Shift_Regs = 1'b1;
                next_state = TEST;
            end
            TEST: begin
                Sub_Regs   = 1'b1;
                Decr_P     = 1'b1;
                next_state = CHECK;
            end
            CHECK: next_state = P_Zero ? DONE : SHIFT;
            DONE: begin
                Ready      = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: rtl/ace_divider.sv
// ace_divider: sequential unsigned restoring divider datapath with Start/Ready handshake
module ace_divider
    import ace_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Ready,
    output logic             Busy,
    output logic             Div_By_Zero,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder
);

    localparam int PW = p_width(WIDTH);

    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q, d;
    logic [PW-1:0]    p;
    logic [WIDTH+1:0] diff;
    logic load_regs, shift_regs, sub_regs, decr_p, set_dbz;

    ace_div_controller u_ctrl (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Div_Zero   (Divisor == '0),
        .P_Zero     (p == '0),
        .Ready      (Ready),
        .Busy       (Busy),
        .Load_Regs  (load_regs),
        .Shift_Regs (shift_regs),
        .Sub_Regs   (sub_regs),
        .Decr_P     (decr_p),
        .Set_DBZ    (set_dbz)
    );

    // one extra bit so the sign of the trial subtraction is explicit
    assign diff = {1'b0, a} - {2'b00, d};

    // Q and A double as the result registers: they only change between LOAD and DONE
    assign Quotient  = q;
    assign Remainder = a[WIDTH-1:0];

    // partial remainder, quotient, divisor and iteration counter
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            a           <= '0;
            q           <= '0;
            d           <= '0;
            p           <= '0;
            Div_By_Zero <= 1'b0;
        end else if (load_regs) begin
            a           <= set_dbz ? {1'b0, Dividend} : '0;
            q           <= set_dbz ? '1 : Dividend;
            d           <= Divisor;
            p           <= PW'(WIDTH);
            Div_By_Zero <= set_dbz;
        end else if (shift_regs) begin
            {a, q} <= {a[WIDTH-1:0], q, 1'b0};
        end else if (sub_regs) begin
            if (!diff[WIDTH+1]) begin
                a    <= diff[WIDTH:0];
                q[0] <= 1'b1;
            end
            if (decr_p)
                p <= p - PW'(1);
        end
    end

endmodule
